// File: rtl/vc_arbiter.sv
// vc_arbiter: four-input virtual-channel arbiter.
//   Drains four VC FIFOs, which present combinational read data, and forwards
//   at most one word per cycle into a single downstream FIFO. The downstream
//   almost-full flag acts as backpressure. Arbitration is round-robin
//   (ARB_MODE=0) or strict priority with VC3 highest (ARB_MODE=1), fixed at
//   elaboration.
//
// Ports:
//   clk              sole clock, rising edge
//   reset_L          asynchronous active-low reset
//   arb_en           arbitration enable, sampled each cycle
//   vc_empty[3:0]    empty flags of VC FIFOs 3..0
//   vc_data0..3      combinational read data of each VC FIFO
//   out_almost_full  downstream almost-full (blocks reads in the same cycle)
//   out_full         downstream full (only used for error detection)
//   vc_rd[3:0]       one-hot read strobes to the VC FIFOs (combinational)
//   out_data         registered word to the downstream FIFO
//   out_wr           registered write strobe to the downstream FIFO
//   state            FSM state: 0 IDLE, 1 ACTIVE, 2 PAUSE
//   pkt_count        words forwarded since reset, wraps modulo 2^CW
//   error_output     sticky: a write was issued while out_full was high
//
// state  | meaning
// IDLE   | not forwarding; waits for enable, data and room downstream
// ACTIVE | forwarding one word per cycle from the granted VC
// PAUSE  | downstream almost full; reads held off until it drains
module vc_arbiter #(
  parameter int BW       = 6,
  parameter int ARB_MODE = 0,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          arb_en,
  input  logic [3:0]    vc_empty,
  input  logic [BW-1:0] vc_data0,
  input  logic [BW-1:0] vc_data1,
  input  logic [BW-1:0] vc_data2,
  input  logic [BW-1:0] vc_data3,
  input  logic          out_almost_full,
  input  logic          out_full,
  output logic [3:0]    vc_rd,
  output logic [BW-1:0] out_data,
  output logic          out_wr,
  output logic [1:0]    state,
  output logic [CW-1:0] pkt_count,
  output logic          error_output
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [1:0]    rr_ptr;
  logic [1:0]    grant;
  logic          grant_valid;
  logic [1:0]    scan_idx;
  logic          any_data;
  logic          rd_en;
  logic [BW-1:0] sel_data;

  assign any_data = ~(&vc_empty);
  assign state    = state_q;

  // Grant search. Round-robin scans downward over the offsets so the
  // smallest offset from rr_ptr is the last (winning) assignment; strict
  // priority scans upward so the highest non-empty index wins.
  always_comb begin
    grant       = rr_ptr;
    grant_valid = 1'b0;
    scan_idx    = 2'd0;
    if (ARB_MODE == 0) begin
      for (int k = 3; k >= 0; k--) begin
        scan_idx = rr_ptr + 2'(k);
        if (!vc_empty[scan_idx]) begin
          grant       = scan_idx;
          grant_valid = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        scan_idx = 2'(k);
        if (!vc_empty[scan_idx]) begin
          grant       = scan_idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_en = (state_q == ST_ACTIVE) && arb_en && !out_almost_full &&
            grant_valid && !vc_empty[grant];
    vc_rd = 4'b0000;
    if (rd_en) begin
      vc_rd = 4'b0001 << grant;
    end
  end

  always_comb begin
    sel_data = vc_data0;
    case (grant)
      2'd0: sel_data = vc_data0;
      2'd1: sel_data = vc_data1;
      2'd2: sel_data = vc_data2;
      2'd3: sel_data = vc_data3;
    endcase
  end

  // Leaving to IDLE takes precedence over pausing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en && any_data && !out_almost_full) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!arb_en || !any_data) begin
          state_d = ST_IDLE;
        end else if (out_almost_full) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (!arb_en) begin
          state_d = ST_IDLE;
        end else if (!out_almost_full && any_data) begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= ST_IDLE;
      rr_ptr       <= 2'd0;
      out_data     <= '0;
      out_wr       <= 1'b0;
      pkt_count    <= '0;
      error_output <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_wr       <= rd_en;
      error_output <= error_output | (out_wr & out_full);
      if (rd_en) begin
        out_data  <= sel_data;
        pkt_count <= pkt_count + CW'(1);
        if (ARB_MODE == 0) begin
          rr_ptr <= grant + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: self-checking bench for vc_arbiter.
//   Two instances share the control inputs: u_rr (round-robin, CW=4) and
//   u_sp (strict priority, CW=8). Each has four queue-backed VC FIFOs that
//   pop on the DUT's read strobes. A behavioural model of each arbiter is
//   checked against every output on every falling edge; directed scenarios
//   add literal expectations on word order, counts and states.
module tb_vc_arbiter;
  localparam int BW = 6;

  logic clk = 1'b0;
  logic reset_L, arb_en, aful, full;

  logic [3:0]    vc_empty_s [2];
  logic [BW-1:0] vc_data_s  [2][4];
  logic [3:0]    vc_rd_s    [2];
  logic [BW-1:0] out_data_s [2];
  logic          out_wr_s   [2];
  logic [1:0]    state_s    [2];
  logic          err_s      [2];
  logic [3:0]    pkt_rr;
  logic [7:0]    pkt_sp;

  logic [BW-1:0] mem [2][4][256];
  logic [7:0]    rp  [2][4];
  logic [7:0]    wp  [2][4];
  logic [3:0]    rd_cap [2];

  logic [BW-1:0] log_w [2][256];
  int            log_n [2];
  int            sp_viol;

  int m_state [2];
  int m_rr    [2];
  int m_wr    [2];
  int m_data  [2];
  int m_cnt   [2];
  int m_err   [2];

  int n_chk  = 0;
  int n_pass = 0;

  int exp_rr [8] = '{'h10, 'h11, 'h12, 'h13, 'h20, 'h21, 'h22, 'h23};
  int exp_sp [5] = '{'h31, 'h32, 'h01, 'h02, 'h03};

  always #5 clk = ~clk;

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < 4; v++) begin
        vc_empty_s[d][v] = (rp[d][v] == wp[d][v]);
        vc_data_s[d][v]  = mem[d][v][rp[d][v]];
      end
    end
  end

  vc_arbiter #(.BW(BW), .ARB_MODE(0), .CW(4)) u_rr (
    .clk(clk), .reset_L(reset_L), .arb_en(arb_en), .vc_empty(vc_empty_s[0]),
    .vc_data0(vc_data_s[0][0]), .vc_data1(vc_data_s[0][1]),
    .vc_data2(vc_data_s[0][2]), .vc_data3(vc_data_s[0][3]),
    .out_almost_full(aful), .out_full(full), .vc_rd(vc_rd_s[0]),
    .out_data(out_data_s[0]), .out_wr(out_wr_s[0]), .state(state_s[0]),
    .pkt_count(pkt_rr), .error_output(err_s[0])
  );

  vc_arbiter #(.BW(BW), .ARB_MODE(1), .CW(8)) u_sp (
    .clk(clk), .reset_L(reset_L), .arb_en(arb_en), .vc_empty(vc_empty_s[1]),
    .vc_data0(vc_data_s[1][0]), .vc_data1(vc_data_s[1][1]),
    .vc_data2(vc_data_s[1][2]), .vc_data3(vc_data_s[1][3]),
    .out_almost_full(aful), .out_full(full), .vc_rd(vc_rd_s[1]),
    .out_data(out_data_s[1]), .out_wr(out_wr_s[1]), .state(state_s[1]),
    .pkt_count(pkt_sp), .error_output(err_s[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Granted VC by the arbitration rule, or -1 when every VC is empty.
  function automatic int pick(input int d, input int rr, input logic [3:0] emp);
    int v;
    for (int k = 0; k < 4; k++) begin
      v = (d == 0) ? (rr + k) % 4 : 3 - k;
      if (!emp[v]) return v;
    end
    return -1;
  endfunction

  task automatic monitor();
    for (int d = 0; d < 2; d++) begin
      int g;
      int rdg;
      int pkt;
      logic [3:0] emp;
      logic [3:0] erd;
      logic [7:0] li;
      string pre;
      pre = (d == 0) ? "rr" : "sp";
      if (!reset_L) begin
        m_state[d] = 0; m_rr[d] = 0; m_wr[d] = 0;
        m_data[d]  = 0; m_cnt[d] = 0; m_err[d] = 0;
      end
      emp = vc_empty_s[d];
      g   = pick(d, m_rr[d], emp);
      rdg = (reset_L && m_state[d] == 1 && arb_en && !aful && g >= 0) ? g : -1;
      erd = (rdg >= 0) ? 4'(1 << rdg) : 4'b0000;
      pkt = (d == 0) ? int'(pkt_rr) : int'(pkt_sp);
      chk({pre, ".state"},    int'(state_s[d]),    m_state[d]);
      chk({pre, ".vc_rd"},    int'(vc_rd_s[d]),    int'(erd));
      chk({pre, ".out_wr"},   int'(out_wr_s[d]),   m_wr[d]);
      chk({pre, ".out_data"}, int'(out_data_s[d]), m_data[d]);
      chk({pre, ".pkt"},      pkt,                 m_cnt[d]);
      chk({pre, ".err"},      int'(err_s[d]),      m_err[d]);
      if (d == 1 && !emp[3] && vc_rd_s[1][0]) sp_viol++;
      if (out_wr_s[d]) begin
        li = 8'(log_n[d]);
        log_w[d][li] = out_data_s[d];
        log_n[d]++;
      end
      rd_cap[d] = vc_rd_s[d];
      if (reset_L) begin
        if (m_wr[d] != 0 && full) m_err[d] = 1;
        if (rdg >= 0) begin
          m_wr[d]   = 1;
          m_data[d] = int'(vc_data_s[d][rdg]);
          m_cnt[d]  = (m_cnt[d] + 1) % ((d == 0) ? 16 : 256);
          if (d == 0) m_rr[d] = (rdg + 1) % 4;
        end else begin
          m_wr[d] = 0;
        end
        case (m_state[d])
          0: if (arb_en && emp != 4'hF && !aful) m_state[d] = 1;
          1: begin
            if (!arb_en || emp == 4'hF) m_state[d] = 0;
            else if (aful) m_state[d] = 2;
          end
          2: begin
            if (!arb_en) m_state[d] = 0;
            else if (!aful && emp != 4'hF) m_state[d] = 1;
          end
          default: m_state[d] = 0;
        endcase
      end
    end
  endtask

  // One clock: model check on the falling edge, FIFO pops just after the
  // rising edge. Returns at posedge+1, where stimulus is applied.
  task automatic cyc();
    logic r;
    @(negedge clk);
    monitor();
    @(posedge clk);
    r = reset_L;
    #1;
    if (r) begin
      for (int d = 0; d < 2; d++)
        for (int v = 0; v < 4; v++)
          if (rd_cap[d][v]) rp[d][v] = rp[d][v] + 8'd1;
    end
  endtask

  task automatic load(input int d, input int v, input logic [BW-1:0] w);
    mem[d][v][wp[d][v]] = w;
    wp[d][v] = wp[d][v] + 8'd1;
  endtask

  task automatic flush();
    for (int d = 0; d < 2; d++)
      for (int v = 0; v < 4; v++) wp[d][v] = rp[d][v];
  endtask

  task automatic do_reset();
    arb_en = 1'b0; aful = 1'b0; full = 1'b0;
    reset_L = 1'b0;
    flush();
    cyc();
    cyc();
    reset_L = 1'b1;
  endtask

  task automatic run_until(input int d, input int target, input int budget, input string nm);
    int i;
    i = 0;
    while (log_n[d] < target && i < budget) begin
      cyc();
      i++;
    end
    chk(nm, log_n[d], target);
  endtask

  initial begin
    int s;
    int s2;
    logic [7:0] li;
    for (int d = 0; d < 2; d++) begin
      log_n[d] = 0;
      rd_cap[d] = 4'b0000;
      for (int v = 0; v < 4; v++) begin
        rp[d][v] = 8'd0;
        wp[d][v] = 8'd0;
      end
    end
    sp_viol = 0;
    reset_L = 1'b0; arb_en = 1'b0; aful = 1'b0; full = 1'b0;
    repeat (3) cyc();
    reset_L = 1'b1;
    cyc();

    chk("rst.state_rr", int'(state_s[0]), 0);
    chk("rst.wr_rr",    int'(out_wr_s[0]), 0);
    chk("rst.pkt_rr",   int'(pkt_rr), 0);
    chk("rst.err_sp",   int'(err_s[1]), 0);

    // Enable with nothing queued, then data with enable low.
    arb_en = 1'b1;
    repeat (4) cyc();
    chk("empty.state_rr", int'(state_s[0]), 0);
    chk("empty.state_sp", int'(state_s[1]), 0);
    arb_en = 1'b0;
    load(0, 2, 6'h05);
    load(0, 2, 6'h06);
    repeat (4) cyc();
    chk("dis.state_rr", int'(state_s[0]), 0);
    chk("dis.vc_rd_rr", int'(vc_rd_s[0]), 0);
    s = log_n[0];
    arb_en = 1'b1;
    run_until(0, s + 2, 20, "en.count");
    li = 8'(s);     chk("en.w0", int'(log_w[0][li]), 'h05);
    li = 8'(s + 1); chk("en.w1", int'(log_w[0][li]), 'h06);

    // Round-robin fairness.
    do_reset();
    for (int v = 0; v < 4; v++) begin
      load(0, v, 6'(8'h10 + v));
      load(0, v, 6'(8'h20 + v));
    end
    s = log_n[0];
    arb_en = 1'b1;
    run_until(0, s + 8, 40, "rr.count");
    for (int i = 0; i < 8; i++) begin
      li = 8'(s + i);
      chk("rr.seq", int'(log_w[0][li]), exp_rr[i]);
    end
    repeat (3) cyc();
    chk("rr.idle", int'(state_s[0]), 0);
    chk("rr.pkt",  int'(pkt_rr), 8);

    // Strict priority.
    do_reset();
    load(1, 0, 6'h01); load(1, 0, 6'h02); load(1, 0, 6'h03);
    load(1, 3, 6'h31); load(1, 3, 6'h32);
    s = log_n[1];
    sp_viol = 0;
    arb_en = 1'b1;
    run_until(1, s + 5, 40, "sp.count");
    for (int i = 0; i < 5; i++) begin
      li = 8'(s + i);
      chk("sp.seq", int'(log_w[1][li]), exp_sp[i]);
    end
    chk("sp.vc0_held", sp_viol, 0);
    repeat (3) cyc();
    chk("sp.pkt",  int'(pkt_sp), 5);
    chk("sp.idle", int'(state_s[1]), 0);

    // Backpressure mid-stream.
    do_reset();
    for (int i = 1; i <= 8; i++) load(0, 0, 6'(i));
    s = log_n[0];
    arb_en = 1'b1;
    run_until(0, s + 3, 20, "bp.pre");
    aful = 1'b1;
    s2 = log_n[0];
    cyc();
    chk("bp.pause", int'(state_s[0]), 2);
    repeat (3) cyc();
    chk("bp.trailing", log_n[0] - s2, 1);
    aful = 1'b0;
    cyc();
    chk("bp.resume", int'(state_s[0]), 1);
    run_until(0, s + 8, 40, "bp.count");
    for (int i = 0; i < 8; i++) begin
      li = 8'(s + i);
      chk("bp.seq", int'(log_w[0][li]), i + 1);
    end
    repeat (3) cyc();

    // Write while downstream full -> sticky error.
    chk("err.pre", int'(err_s[0]), 0);
    load(0, 1, 6'h2A); load(0, 1, 6'h2B); load(0, 1, 6'h2C);
    s = log_n[0];
    run_until(0, s + 1, 20, "err.stream");
    chk("err.wr_pre", int'(out_wr_s[0]), 1);
    full = 1'b1;
    cyc();
    full = 1'b0;
    chk("err.set", int'(err_s[0]), 1);
    repeat (5) cyc();
    chk("err.sticky", int'(err_s[0]), 1);
    chk("err.sp_clear", int'(err_s[1]), 0);

    // Counter wrap with CW=4: 17 words leave the count at 1.
    do_reset();
    for (int i = 0; i < 17; i++) load(0, i % 4, 6'(i + 1));
    s = log_n[0];
    arb_en = 1'b1;
    run_until(0, s + 17, 80, "wrap.count");
    repeat (3) cyc();
    chk("wrap.pkt", int'(pkt_rr), 1);

    // Asynchronous reset while a word is on the output.
    do_reset();
    for (int i = 0; i < 4; i++) load(0, 2, 6'(8'h07 + i));
    s = log_n[0];
    arb_en = 1'b1;
    run_until(0, s + 1, 20, "rstm.stream");
    chk("rstm.wr_pre", int'(out_wr_s[0]), 1);
    #1;
    reset_L = 1'b0;
    #1;
    chk("rstm.wr",    int'(out_wr_s[0]), 0);
    chk("rstm.data",  int'(out_data_s[0]), 0);
    chk("rstm.pkt",   int'(pkt_rr), 0);
    chk("rstm.state", int'(state_s[0]), 0);
    chk("rstm.vc_rd", int'(vc_rd_s[0]), 0);
    arb_en = 1'b0;
    flush();
    cyc();
    cyc();
    reset_L = 1'b1;
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

Four-input virtual-channel arbiter that drains the per-VC FIFOs and forwards one word per cycle into a single downstream FIFO. It sits directly downstream of the four VC FIFO instances, which present combinational read data. It also sits upstream of the output FIFO, whose almost-full flag it honours as backpressure. Arbitration is round-robin or strict priority, fixed at elaboration.

## Interface
- BW, 6, data word width (matches the VC FIFOs)
- ARB_MODE, 0, 0 = round-robin, 1 = strict priority (VC3 highest, VC0 lowest)
- CW, 8, width of the forwarded-word counter
- clk  input  1  sole clock, rising edge
- reset_L  input  1  reset; asynchronous and active-low
- arb_en  input  1  arbitration enable; sampled each cycle
- vc_empty  input  4  empty flags of VC FIFOs 3..0
- vc_data0..vc_data3  input  BW each  combinational read data of each VC FIFO
- out_almost_full  input  1  almost-full flag of the downstream FIFO
- out_full  input  1  full flag of the downstream FIFO
- vc_rd  output  4  one-hot read strobes to the VC FIFOs (combinational)
- out_data  output  BW  registered word to the downstream FIFO
- out_wr  output  1  registered write strobe to the downstream FIFO
- state  output  2  FSM state: 0 IDLE, 1 ACTIVE, 2 PAUSE
- pkt_count  output  CW  words forwarded since reset; wraps modulo 2^CW
- error_output  output  1  sticky: a write was issued while out_full was high

## Operation
- FSM, registered:
  - IDLE -> ACTIVE when arb_en & |(~vc_empty) & ~out_almost_full.
  - ACTIVE -> IDLE when ~arb_en or all vc_empty are high.
  - ACTIVE -> PAUSE when out_almost_full (and the ACTIVE -> IDLE condition is false).
  - PAUSE -> IDLE when ~arb_en.
  - PAUSE -> ACTIVE when ~out_almost_full & |(~vc_empty).
  - PAUSE stays when ~out_almost_full but all VCs are empty.
  - Priority of exits: the IDLE exit beats the PAUSE exit.
- Grant, combinational:
  - Round-robin: the first non-empty VC searched upward from the 2-bit pointer rr_ptr, wrapping 3 -> 0.
  - Strict priority: the highest-index non-empty VC.
- vc_rd[i] = (state==ACTIVE) & grant==i & ~vc_empty[i] & ~out_almost_full & arb_en.
  - At most one bit is set per cycle.
  - Never set for an empty VC, so no FIFO underrun can originate here.
- rr_ptr reset value is 0. On each read of VC i, rr_ptr <= (i+1) mod 4. Unchanged in strict mode.
- Data path, on the edge following a read cycle:
  - out_data <= vc_data of the granted VC.
  - out_wr <= 1.
  - pkt_count <= pkt_count + 1.
  - Otherwise out_wr <= 0 and out_data holds its value.
- error_output is set when out_wr & out_full are both high. It clears only on reset.
- Async reset, all registered outputs:
  - state IDLE, out_data 0, out_wr 0, pkt_count 0, error_output 0, rr_ptr 0.
  - vc_rd therefore evaluates to 0.
  - Reset asserted mid-transfer discards any in-flight word: out_wr drops immediately.

## Timing
- Read-to-write latency is 1 cycle: vc_rd in cycle N gives out_wr/out_data valid in cycle N+1.
- Throughput is 1 word/cycle while in ACTIVE with data available and no backpressure.
- First read occurs 1 cycle after the IDLE -> ACTIVE edge.
- Backpressure:
  - out_almost_full blocks vc_rd in the same cycle (combinational).
  - At most 1 word is in flight. The downstream almost-full threshold must leave ≥1 free slot.
- Simultaneous case: if vc_empty of the granted VC rises in the same cycle it is read, the read still completes. The empty flag reflects the pre-edge fill.
- pkt_count wraps 2^CW-1 -> 0 with no flag.

## Test plan
- Reset mid-stream:
  - Stimulus: reset_L driven low asynchronously while out_wr=1.
  - Required response: out_wr, out_data, pkt_count and state go to 0 before the next edge; vc_rd=0.
- Round-robin fairness:
  - Stimulus: ARB_MODE=0, all 4 VCs preloaded with 2 words (VCn holds 0x10+n, 0x20+n), arb_en=1.
  - Required response: out_data sequence 0x10, 0x11, 0x12, 0x13, 0x20, 0x21, 0x22, 0x23 on consecutive out_wr cycles; pkt_count=8; state returns to IDLE.
- Strict priority:
  - Stimulus: ARB_MODE=1, VC0 holds 3 words, VC3 holds 2 words.
  - Required response: both VC3 words appear first, then the VC0 words; vc_rd[0] stays 0 while VC3 is non-empty.
- Backpressure:
  - Stimulus: out_almost_full raised for 4 cycles during a stream.
  - Required response: vc_rd=0 in the same cycle; state=PAUSE the next cycle; exactly 1 trailing out_wr; resume to ACTIVE 1 cycle after the flag drops; no words lost or duplicated.
- Enable and empty:
  - Stimulus: arb_en=0 with data present.
  - Required response: state stays IDLE and vc_rd=0.
  - Stimulus: arb_en=1 with all VCs empty.
  - Required response: no transition out of IDLE.
- Error and wrap:
  - Stimulus: force out_full=1 while out_wr=1.
  - Required response: error_output=1 and it stays set.
  - Stimulus: CW=4, forward 17 words.
  - Required response: pkt_count reads 1.
